fft_peak_search: RTL and testbench

FFT_PEAK_SEARCH -- requirements
Module: fft_peak_search

---
 rtl/fft_peak_pkg.sv | 28 ++
 rtl/fft_peak_mag.sv | 39 +++
 rtl/fft_peak_search.sv | 189 ++++++++++++++++++
 tb/tb_fft_peak_search.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_peak_pkg.sv
// Shared constants and types for the FFT peak search block.
package fft_peak_pkg;

  localparam int FFT_POINT_DEF     = 32768;
  localparam int ADDR_WIDTH_DEF    = 15;
  localparam int FFT_OUT_WIDTH_DEF = 30;
  localparam int MAG_WIDTH         = 2 * FFT_OUT_WIDTH_DEF + 1;
  localparam logic [31:0] NO_PEAK_INDEX = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cnt_state_e;

  typedef struct packed {
    logic        valid;
    logic        first;
    logic        last;
    logic        err;
    logic        in_win;
    logic [31:0] idx;
  } beat_tag_t;

  function automatic int mag_width(input int comp_width);
    return 2 * comp_width + 1;
  endfunction

endpackage

// File: rtl/fft_peak_mag.sv
// Two-stage magnitude datapath: squares registered on the first edge, I^2+Q^2 on the second.
module fft_peak_mag
  import fft_peak_pkg::*;
#(
  parameter int FFT_OUT_WIDTH = FFT_OUT_WIDTH_DEF,
  localparam int MAG_W        = 2 * FFT_OUT_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [FFT_OUT_WIDTH-1:0] i_i,
  input  logic signed [FFT_OUT_WIDTH-1:0] i_q,
  output logic        [MAG_W-1:0]         o_mag
);

  logic signed [2*FFT_OUT_WIDTH-1:0] sq_i_d, sq_i_q, sq_q_d, sq_q_q;
  logic        [MAG_W-1:0]           mag_d, mag_q;

  always_comb begin
    sq_i_d = i_i * i_i;
    sq_q_d = i_q * i_q;
    // squares are non-negative, so zero-extension is exact
    mag_d  = {1'b0, sq_i_q} + {1'b0, sq_q_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_i_q <= '0;
      sq_q_q <= '0;
      mag_q  <= '0;
    end else begin
      sq_i_q <= sq_i_d;
      sq_q_q <= sq_q_d;
      mag_q  <= mag_d;
    end
  end

  assign o_mag = mag_q;

endmodule

// File: rtl/fft_peak_search.sv
// Per-frame peak magnitude search over a bin window; 3-cycle latency from last beat to result.
// Build option: define PEAK_DC_SKIP_EN to exclude bin 0 from the search.
module fft_peak_search
  import fft_peak_pkg::*;
#(
  parameter int FFT_POINT     = FFT_POINT_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int FFT_OUT_WIDTH = FFT_OUT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        i_flow_FFT_data,
  input  logic               i_flow_FFT_valid,
  input  logic               i_flow_FFT_last,
  input  logic [31:0]        i_min_bin,
  input  logic [31:0]        i_max_bin,
  output logic [31:0]        o_peak_index,
  output logic signed [31:0] o_peak_I,
  output logic signed [31:0] o_peak_Q,
  output logic [63:0]        o_peak_mag,
  output logic               o_peak_valid,
  output logic               o_frame_err
);

  localparam int W     = FFT_OUT_WIDTH;
  localparam int MAG_W = mag_width(FFT_OUT_WIDTH);

  cnt_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, beat_idx;
  logic [31:0]           win_min_q, win_min_d, win_max_q, win_max_d;
  logic [31:0]           eff_min, eff_max, idx32;
  logic                  beat_first, at_term;
  beat_tag_t             s0_d, s0_q, s1_q, s2_q;
  logic signed [W-1:0]   in_i, in_q, i0_q, q0_q, i1_q, q1_q, i2_q, q2_q;
  logic [MAG_W-1:0]      mag;

  logic [MAG_W-1:0]      base_mag, new_mag, best_mag_d, best_mag_q;
  logic [31:0]           base_idx, new_idx, best_idx_d, best_idx_q;
  logic signed [W-1:0]   base_i, base_q, new_i, new_q;
  logic signed [W-1:0]   best_i_d, best_i_q, best_q_d, best_q_q;
  logic                  take;

  logic [31:0]           peak_idx_d, peak_idx_q;
  logic signed [31:0]    peak_i_d, peak_i_q, peak_q_d, peak_q_q;
  logic [63:0]           peak_mag_d, peak_mag_q;
  logic                  peak_valid_d, peak_valid_q, frame_err_d, frame_err_q;

  logic                  unused_data_bits;
  assign unused_data_bits = ^{i_flow_FFT_data[63:32+W], i_flow_FFT_data[31:W]};

  assign in_i = i_flow_FFT_data[0 +: W];
  assign in_q = i_flow_FFT_data[32 +: W];

  // Beat counter FSM; the window seen by a frame's first beat is the one latched for the frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_min_d  = win_min_q;
    win_max_d  = win_max_q;
    beat_first = (state_q == ST_IDLE);
    beat_idx   = beat_first ? '0 : cnt_q;
    idx32      = 32'(beat_idx);
    at_term    = (beat_idx == ADDR_WIDTH'(FFT_POINT - 1));
    eff_min    = beat_first ? i_min_bin : win_min_q;
    eff_max    = beat_first ? i_max_bin : win_max_q;

    s0_d        = '0;
    s0_d.valid  = i_flow_FFT_valid;
    s0_d.first  = beat_first;
    s0_d.last   = i_flow_FFT_last | at_term;
    s0_d.err    = i_flow_FFT_last ^ at_term;
    s0_d.idx    = idx32;
`ifdef PEAK_DC_SKIP_EN
    s0_d.in_win = (idx32 >= eff_min) && (idx32 <= eff_max) && (idx32 != 32'd0);
`else
    s0_d.in_win = (idx32 >= eff_min) && (idx32 <= eff_max);
`endif

    if (i_flow_FFT_valid) begin
      if (beat_first) begin
        win_min_d = i_min_bin;
        win_max_d = i_max_bin;
      end
      cnt_d   = beat_idx + 1'b1;
      state_d = s0_d.last ? ST_IDLE : ST_RUN;
    end
  end

  fft_peak_mag #(.FFT_OUT_WIDTH(W)) u_mag (
    .clk   (clk),
    .rst   (rst),
    .i_i   (i0_q),
    .i_q   (q0_q),
    .o_mag (mag)
  );

  // A first-tagged beat compares against an empty best rather than the previous frame.
  always_comb begin
    base_mag = s2_q.first ? '0 : best_mag_q;
    base_idx = s2_q.first ? NO_PEAK_INDEX : best_idx_q;
    base_i   = s2_q.first ? '0 : best_i_q;
    base_q   = s2_q.first ? '0 : best_q_q;
    take     = s2_q.valid && s2_q.in_win && (mag > base_mag);
    new_mag  = take ? mag : base_mag;
    new_idx  = take ? s2_q.idx : base_idx;
    new_i    = take ? i2_q : base_i;
    new_q    = take ? q2_q : base_q;

    best_mag_d = s2_q.valid ? new_mag : best_mag_q;
    best_idx_d = s2_q.valid ? new_idx : best_idx_q;
    best_i_d   = s2_q.valid ? new_i : best_i_q;
    best_q_d   = s2_q.valid ? new_q : best_q_q;

    peak_idx_d   = peak_idx_q;
    peak_i_d     = peak_i_q;
    peak_q_d     = peak_q_q;
    peak_mag_d   = peak_mag_q;
    peak_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (s2_q.valid && s2_q.last) begin
      peak_idx_d   = new_idx;
      peak_i_d     = 32'(new_i);
      peak_q_d     = 32'(new_q);
      peak_mag_d   = 64'(new_mag);
      peak_valid_d = 1'b1;
      frame_err_d  = s2_q.err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      win_min_q    <= '0;
      win_max_q    <= '0;
      s0_q         <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      i0_q         <= '0;
      q0_q         <= '0;
      i1_q         <= '0;
      q1_q         <= '0;
      i2_q         <= '0;
      q2_q         <= '0;
      best_mag_q   <= '0;
      best_idx_q   <= NO_PEAK_INDEX;
      best_i_q     <= '0;
      best_q_q     <= '0;
      peak_idx_q   <= '0;
      peak_i_q     <= '0;
      peak_q_q     <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_min_q    <= win_min_d;
      win_max_q    <= win_max_d;
      s0_q         <= s0_d;
      s1_q         <= s0_q;
      s2_q         <= s1_q;
      i0_q         <= in_i;
      q0_q         <= in_q;
      i1_q         <= i0_q;
      q1_q         <= q0_q;
      i2_q         <= i1_q;
      q2_q         <= q1_q;
      best_mag_q   <= best_mag_d;
      best_idx_q   <= best_idx_d;
      best_i_q     <= best_i_d;
      best_q_q     <= best_q_d;
      peak_idx_q   <= peak_idx_d;
      peak_i_q     <= peak_i_d;
      peak_q_q     <= peak_q_d;
      peak_mag_q   <= peak_mag_d;
      peak_valid_q <= peak_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign o_peak_index = peak_idx_q;
  assign o_peak_I     = peak_i_q;
  assign o_peak_Q     = peak_q_q;
  assign o_peak_mag   = peak_mag_q;
  assign o_peak_valid = peak_valid_q;
  assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_search.sv
// Directed bench for fft_peak_search: hand-computed peaks, windows, frame errors and reset.
module tb_fft_peak_search;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data;
  logic        valid, last;
  logic [31:0] min_bin, max_bin;
  logic [31:0] peak_index;
  logic signed [31:0] peak_i, peak_q;
  logic [63:0] peak_mag;
  logic        peak_valid, frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int end_e0 = 0;
  int orphan_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] idx;
    logic [31:0] pi;
    logic [31:0] pq;
    logic [63:0] mag;
    logic        err;
  } pulse_t;
  pulse_t pulses[$];

  fft_peak_search dut (
    .clk              (clk),
    .rst              (rst),
    .i_flow_FFT_data  (data),
    .i_flow_FFT_valid (valid),
    .i_flow_FFT_last  (last),
    .i_min_bin        (min_bin),
    .i_max_bin        (max_bin),
    .o_peak_index     (peak_index),
    .o_peak_I         (peak_i),
    .o_peak_Q         (peak_q),
    .o_peak_mag       (peak_mag),
    .o_peak_valid     (peak_valid),
    .o_frame_err      (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (peak_valid) begin
      pulse_t p;
      p.cyc = cyc; p.idx = peak_index; p.pi = peak_i; p.pq = peak_q;
      p.mag = peak_mag; p.err = frame_err;
      pulses.push_back(p);
    end
    if (frame_err && !peak_valid) orphan_err++;
  end

  function automatic logic [63:0] bin(input int i, input int q);
    return {q, i};
  endfunction

  task automatic send_frame(input int n, input bit give_last, input int gap,
                            input int pa, input logic [63:0] da,
                            input int pb, input logic [63:0] db,
                            input bit re_win, input logic [31:0] nmin, input logic [31:0] nmax);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && (i % gap) == gap - 1) begin
        @(negedge clk);
        valid = 1'b0; last = 1'b0; data = '0;
      end
      @(negedge clk);
      if (re_win && i == 1) begin
        min_bin = nmin;
        max_bin = nmax;
      end
      valid  = 1'b1;
      data   = (i == pa) ? da : ((i == pb) ? db : 64'd0);
      last   = give_last && (i == n - 1);
      end_e0 = cyc + 1;
    end
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0; last = 1'b0; data = '0;
    end
  endtask

  task automatic expect_pulse(input string tag, input logic [31:0] e_idx,
                              input int e_i, input int e_q, input logic [63:0] e_mag,
                              input logic e_err, input bit chk_lat);
    int waited = 0;
    pulse_t r;
    while (pulses.size() == 0 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (pulses.size() > 0) else begin
      failures++;
      $error("FAIL %s_pulse observed=none expected=pulse", tag);
    end
    if (pulses.size() > 0) begin
      r = pulses.pop_front();
      checks++;
      assert (r.idx === e_idx) else begin
        failures++; $error("FAIL %s_index observed=%0h expected=%0h", tag, r.idx, e_idx);
      end
      checks++;
      assert (r.pi === 32'(e_i)) else begin
        failures++; $error("FAIL %s_I observed=%0h expected=%0h", tag, r.pi, 32'(e_i));
      end
      checks++;
      assert (r.pq === 32'(e_q)) else begin
        failures++; $error("FAIL %s_Q observed=%0h expected=%0h", tag, r.pq, 32'(e_q));
      end
      checks++;
      assert (r.mag === e_mag) else begin
        failures++; $error("FAIL %s_mag observed=%0d expected=%0d", tag, r.mag, e_mag);
      end
      checks++;
      assert (r.err === e_err) else begin
        failures++; $error("FAIL %s_err observed=%b expected=%b", tag, r.err, e_err);
      end
      if (chk_lat) begin
        checks++;
        assert (r.cyc - end_e0 === 3) else begin
          failures++; $error("FAIL %s_latency observed=%0d expected=3", tag, r.cyc - end_e0);
        end
      end
    end
  endtask

  initial begin
    longint big;
    rst = 1'b0; valid = 1'b0; last = 1'b0; data = '0;
    min_bin = 32'd0; max_bin = 32'd32767;
    repeat (3) @(negedge clk);

    checks++;
    assert (peak_index === 32'd0) else begin
      failures++; $error("FAIL rst_index observed=%0h expected=0", peak_index);
    end
    checks++;
    assert (peak_mag === 64'd0) else begin
      failures++; $error("FAIL rst_mag observed=%0d expected=0", peak_mag);
    end
    checks++;
    assert ({peak_valid, frame_err} === 2'b00) else begin
      failures++; $error("FAIL rst_pulses observed=%b expected=00", {peak_valid, frame_err});
    end
    rst = 1'b1;
    go_idle(2);

    // full frame with last at the terminal bin
    send_frame(32768, 1'b1, 0, 100, bin(1000, -1000), -1, 64'd0, 1'b0, 0, 0);
    go_idle(1);
    expect_pulse("single_peak", 32'd100, 1000, -1000, 64'd2000000, 1'b0, 1'b1);

    // full frame without last: implicit end at the terminal bin, tie keeps lower index
    send_frame(32768, 1'b0, 0, 50, bin(300, 400), 60, bin(300, 400), 1'b0, 0, 0);
    go_idle(1);
    expect_pulse("tie_implicit", 32'd50, 300, 400, 64'd250000, 1'b1, 1'b1);

    // window excludes the larger bin; gaps in the stream
    min_bin = 32'd100; max_bin = 32'd300;
    send_frame(301, 1'b1, 7, 10, bin(5000, 0), 200, bin(100, 0), 1'b0, 0, 0);
    go_idle(1);
    expect_pulse("window", 32'd200, 100, 0, 64'd10000, 1'b1, 1'b1);

    // empty window (min > max); widened mid-frame, must not apply until next frame
    min_bin = 32'd10; max_bin = 32'd5;
    send_frame(20, 1'b1, 0, 4, bin(9, 9), -1, 64'd0, 1'b1, 32'd0, 32'd100);
    go_idle(1);
    expect_pulse("empty_win", 32'hFFFF_FFFF, 0, 0, 64'd0, 1'b1, 1'b0);

    // back-to-back frames, second peak smaller than the first
    min_bin = 32'd0; max_bin = 32'd32767;
    send_frame(20, 1'b1, 0, 5, bin(7, 0), -1, 64'd0, 1'b0, 0, 0);
    send_frame(20, 1'b1, 0, 7, bin(3, 0), -1, 64'd0, 1'b0, 0, 0);
    go_idle(1);
    expect_pulse("b2b_first", 32'd5, 7, 0, 64'd49, 1'b1, 1'b0);
    expect_pulse("b2b_second", 32'd7, 3, 0, 64'd9, 1'b1, 1'b1);

    // short frame: last at bin 1000
    send_frame(1001, 1'b1, 0, 321, bin(-20, 30), -1, 64'd0, 1'b0, 0, 0);
    go_idle(1);
    expect_pulse("short_last", 32'd321, -20, 30, 64'd1300, 1'b1, 1'b1);

    // reset in the middle of a frame discards it
    send_frame(501, 1'b0, 0, 100, bin(50, 50), -1, 64'd0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; data = '0;
    @(negedge clk);
    checks++;
    assert (peak_index === 32'd0) else begin
      failures++; $error("FAIL midrst_index observed=%0h expected=0", peak_index);
    end
    checks++;
    assert ({peak_i, peak_q, peak_mag} === 128'd0) else begin
      failures++; $error("FAIL midrst_data observed=%0h expected=0", {peak_i, peak_q, peak_mag});
    end
    repeat (8) @(negedge clk);
    checks++;
    assert (pulses.size() === 0) else begin
      failures++; $error("FAIL midrst_pulse observed=%0d expected=0", pulses.size());
    end
    rst = 1'b1;
    go_idle(2);

    // DC bin handling, first frame after reset
    min_bin = 32'd0; max_bin = 32'd10;
    send_frame(11, 1'b1, 0, 0, bin(536870911, 0), 3, bin(5, 0), 1'b0, 0, 0);
    go_idle(1);
`ifdef PEAK_DC_SKIP_EN
    expect_pulse("dc_bin", 32'd3, 5, 0, 64'd25, 1'b1, 1'b1);
`else
    big = 64'd536870911;
    big = big * big;
    expect_pulse("dc_bin", 32'd0, 536870911, 0, 64'(big), 1'b1, 1'b1);
`endif

    go_idle(4);
    checks++;
    assert (orphan_err === 0) else begin
      failures++; $error("FAIL err_without_valid observed=%0d expected=0", orphan_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
